count_load_ctrl: RTL and testbench
==================================

# count_load_ctrl

Upstream command stage for the loadable up-counter. It accepts (start, terminal) count jobs over a valid/ready handshake and buffers them in a small FIFO. For each job it drives the counter's `load`/`d` inputs with a one-cycle load pulse, then watches the counter's `q` until it equals the job's terminal value. It signals completion with a one-cycle `done` pulse and then moves on to the next job.

## Interface
- `WIDTH`, default 4: counter width; width of start, terminal and `q`.
- `DEPTH`, default 2: job FIFO depth; must be a power of two and ≥2.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset; asynchronous, active-low.
- `in_valid`, input, 1: a job is offered.
- `in_ready`, output, 1: FIFO can accept a job (`!full`).
- `in_start`, input, WIDTH: value to preset into the counter.
- `in_term`, input, WIDTH: count value that ends the job.
- `abort`, input, 1: cancel the job currently in LOAD or RUN.
- `cnt_q`, input, WIDTH: counter output `q`, fed back.
- `load`, output, 1: counter load strobe.
- `d`, output, WIDTH: counter preset value.
- `busy`, output, 1: a job is in LOAD or RUN.
- `done`, output, 1: one-cycle job-complete pulse.
- `level`, output, clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Push:** a job is pushed when `in_valid && in_ready`; `{in_start, in_term}` is stored as one entry.
- **FSM states:** IDLE, LOAD, RUN, DONE.
- **IDLE:** if the FIFO is non-empty, go to LOAD. On that transition:
  - pop the head entry;
  - register `d <= start`;
  - latch `term_r <= term`.
- **LOAD:** `load = 1` for exactly this one cycle; always go to RUN next.
- **RUN:** if `cnt_q == term_r`, go to DONE; otherwise stay in RUN.
- **DONE:** `done = 1` for this one cycle; always go to IDLE next.
- **Abort:** `abort` high in LOAD or RUN forces IDLE next. No `done` pulse is produced and the FIFO is untouched (the popped job is discarded). `abort` has no effect in IDLE or DONE.
- **Decoded outputs:**
  - `load = (state==LOAD)`
  - `busy = (state==LOAD || state==RUN)`
  - `done = (state==DONE)`
- **`d` holding:** `d` holds its value until the next IDLE→LOAD transition.
- **Simultaneous push and pop:** on a non-full FIFO both take effect and `level` is unchanged.
- **Full FIFO:** `in_ready = 0`, so no push is possible while full.
- **Arithmetic:**
  - The comparison is plain equality on WIDTH bits.
  - The counter wraps modulo 2^WIDTH, so a terminal below the start is reached after wrap-around.
  - The block performs no arithmetic on `cnt_q`.
- **Reset (rst low):**
  - state = IDLE;
  - FIFO emptied (`level = 0`, `in_ready = 1`);
  - `d = 0`, `term_r = 0`;
  - `load = 0`, `busy = 0`, `done = 0`.
- **Reset mid-job:** same as above. The in-flight job and all queued jobs are lost, and no `done` pulse is produced.

## Timing
- **Push to load:** a job pushed at edge k gives IDLE→LOAD at edge k+1. `load` is high from k+1 to k+2, and the counter loads at edge k+2.
- **First compare:** RUN's first cycle sees `cnt_q == start`. A job with start == terminal therefore reaches DONE one edge after entering RUN.
- **Job duration:** for N = (term − start) mod 2^WIDTH, RUN lasts N+1 cycles.
- **Job overhead:** the minimum spacing between consecutive load pulses is N+4 cycles (IDLE, LOAD, RUN×(N+1), DONE).
- **Input-to-output paths:**
  - `in_ready` and `level` follow the registered FIFO count with no combinational path from `in_valid`.
  - `cnt_q` affects state only, never outputs combinationally.

## Structure
- **Shared package `count_load_pkg`:**
  - state enum (IDLE, LOAD, RUN, DONE);
  - job entry struct `{start, term}` of width 2×WIDTH;
  - encoding constants.
- **Sub-module `cnt_cmd_fifo`:** synchronous FIFO with ports `push`, `pop`, `wdata`, `rdata` (head, show-ahead), `full`, `empty`, `level`. It has its own async active-low reset.
- **Top level:** FSM plus the `d`/`term_r` registers.

## Test plan
- **Basic job:** after reset, push {6,9} with `cnt_q` driven by a counter model.
  - One `load` pulse with `d = 6`.
  - RUN sees `cnt_q` 6, 7, 8, 9.
  - `done` pulses once, 5 cycles after `load`.
  - `level` returns to 0.
- **Start equals terminal:** push {3,3}. `done` occurs 2 cycles after `load` (LOAD, RUN×1, DONE).
- **Wrap-around:** push {14,1}. RUN sees 14, 15, 0, 1, followed by a single `done`; no early match.
- **Backpressure:** with DEPTH=2 and the FSM busy, offer 3 jobs back-to-back.
  - The third is held with `in_ready = 0` until the first pop.
  - All three are executed in order, each with the correct `d`.
- **Abort:** push {0,15}, then assert `abort` on the 4th RUN cycle.
  - No `done` pulse.
  - IDLE next cycle.
  - A queued job {2,4} then loads `d = 2` normally.
- **Reset mid-job:** drop `rst` during RUN with 1 job queued.
  - Immediately: `busy = 0`, `load = 0`, `done = 0`, `level = 0`, `d = 0`.
  - After release, no load pulse occurs until a new push.

Source files
------------

// File: rtl/count_load_pkg.sv
// Shared types for the count/load command stage: FSM state encoding.
package count_load_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } cl_state_e;

endpackage

// File: rtl/cnt_cmd_fifo.sv
// Show-ahead synchronous job FIFO; rdata always presents the head entry.
module cnt_cmd_fifo #(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/count_load_ctrl.sv
// Command stage for a loadable up-counter: queues (start, term) jobs, pulses load,
// watches the counter until it reaches term, then pulses done.
module count_load_ctrl
    import count_load_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_start,
    input  logic [WIDTH-1:0] in_term,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             load,
    output logic [WIDTH-1:0] d,
    output logic             busy,
    output logic             done,
    output logic [LW-1:0]    level,
    output cl_state_e        state_dbg
);

    // Handshake: a job is taken on any rising edge where in_valid && in_ready;
    // in_ready depends only on registered FIFO occupancy.
    typedef struct packed {
        logic [WIDTH-1:0] start;
        logic [WIDTH-1:0] term;
    } job_t;

    cl_state_e        state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             pop;
    logic             fifo_full, fifo_empty;
    job_t             head;
    job_t             wjob;

    assign wjob = '{start: in_start, term: in_term};

    cnt_cmd_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full),
        .pop   (pop),
        .wdata (wjob),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                    pop     = 1'b1;
                end
            end
            ST_LOAD: state_d = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort)                 state_d = ST_IDLE;
                else if (cnt_q == term_q)  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // d and term are captured only on the IDLE->LOAD pop and held otherwise.
    assign d_d    = pop ? head.start : d_q;
    assign term_d = pop ? head.term  : term_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            term_q  <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            term_q  <= term_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign d         = d_q;
    assign load      = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_count_load_ctrl.sv
// Bench for count_load_ctrl: job-level timing model plus directed and random jobs.
module tb_count_load_ctrl;

    localparam int W     = 4;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int MASK  = (1 << W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          abort    = 1'b0;
    logic [W-1:0]  in_start = '0;
    logic [W-1:0]  in_term  = '0;
    logic [W-1:0]  cnt_q    = '0;
    logic          in_ready, load, busy, done;
    logic [W-1:0]  d;
    logic [LW-1:0] level;
    count_load_pkg::cl_state_e state_dbg;

    count_load_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_start  (in_start),
        .in_term   (in_term),
        .abort     (abort),
        .cnt_q     (cnt_q),
        .load      (load),
        .d         (d),
        .busy      (busy),
        .done      (done),
        .level     (level),
        .state_dbg (state_dbg)
    );

    // The loadable up-counter this block controls.
    always @(posedge clk) begin
        if (load) cnt_q <= d;
        else      cnt_q <= cnt_q + 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // A job occupies cycles t = 0 (load), 1..N+1 (counting), N+2 (done pulse),
    // where N = (term - start) mod 2^W; the cycle after that is idle.
    logic [2*W-1:0] exp_q[$];
    bit             m_act;
    int             m_t, m_n;
    logic [W-1:0]   m_d;
    logic [2*W-1:0] m_job;
    bit             m_push;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_act = 0; m_t = 0; m_n = 0; m_d = '0;
        end else begin
            m_push = in_valid && (exp_q.size() < DEPTH);
            if (m_act) begin
                if (abort && m_t <= m_n + 1) m_act = 0;
                else if (m_t == m_n + 2)     m_act = 0;
                else                         m_t++;
            end else if (exp_q.size() > 0) begin
                m_job = exp_q.pop_front();
                m_act = 1;
                m_t   = 0;
                m_d   = m_job[2*W-1:W];
                m_n   = (int'(m_job[W-1:0]) - int'(m_job[2*W-1:W])) & MASK;
            end
            if (m_push) exp_q.push_back({in_start, in_term});
        end
    end

    // ---------------- scoreboard compare + event logs ----------------
    int load_cyc[$], load_d[$], done_cyc[$], run_cnt[$];

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(exp_q.size() < DEPTH));
        chk("level",    int'(level),    exp_q.size());
        chk("load",     int'(load),     int'(m_act && m_t == 0));
        chk("busy",     int'(busy),     int'(m_act && m_t <= m_n + 1));
        chk("done",     int'(done),     int'(m_act && m_t == m_n + 2));
        chk("d",        int'(d),        int'(m_d));
        if (load) begin
            load_cyc.push_back(cyc);
            load_d.push_back(int'(d));
        end
        if (busy && !load) run_cnt.push_back(int'(cnt_q));
        if (done) done_cyc.push_back(cyc);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        load_cyc.delete(); load_d.delete(); done_cyc.delete(); run_cnt.delete();
    endtask

    task automatic push_job(input int s, input int t, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_start = W'(s);
        in_term  = W'(t);
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (waited >= 200) chk("push_timeout", waited, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || done || load || level != 0) && g < 500) begin
            tick();
            g++;
        end
        chk("idle_timeout", int'(g < 500), 1);
        tick(2);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    int w, w1, w2, w3, g;
    int s, t;

    initial begin
        tick(2);
        chk("rst_level", int'(level), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_d", int'(d), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        tick(2);

        // basic job {6,9}
        clear_logs();
        push_job(6, 9, w);
        wait_idle();
        chk("basic_nload", load_d.size(), 1);
        chk("basic_d", qget(load_d, 0), 6);
        chk("basic_nrun", run_cnt.size(), 4);
        for (int i = 0; i < 4; i++) chk("basic_run", qget(run_cnt, i), 6 + i);
        chk("basic_ndone", done_cyc.size(), 1);
        chk("basic_lat", qget(done_cyc, 0) - qget(load_cyc, 0), 5);
        chk("basic_level", int'(level), 0);

        // start == terminal
        clear_logs();
        push_job(3, 3, w);
        wait_idle();
        chk("eq_ndone", done_cyc.size(), 1);
        chk("eq_lat", qget(done_cyc, 0) - qget(load_cyc, 0), 2);

        // wrap-around {14,1}
        clear_logs();
        push_job(14, 1, w);
        wait_idle();
        chk("wrap_nrun", run_cnt.size(), 4);
        chk("wrap_run0", qget(run_cnt, 0), 14);
        chk("wrap_run1", qget(run_cnt, 1), 15);
        chk("wrap_run2", qget(run_cnt, 2), 0);
        chk("wrap_run3", qget(run_cnt, 3), 1);
        chk("wrap_ndone", done_cyc.size(), 1);
        chk("wrap_lat", qget(done_cyc, 0) - qget(load_cyc, 0), 5);

        // backpressure: FSM busy, three jobs back-to-back
        clear_logs();
        push_job(0, 12, w);
        tick(2);
        push_job(5, 6, w1);
        push_job(9, 11, w2);
        push_job(13, 13, w3);
        chk("bp_first_nowait", w1, 0);
        chk("bp_third_held", int'(w3 > 0), 1);
        wait_idle();
        chk("bp_nload", load_d.size(), 4);
        chk("bp_d0", qget(load_d, 0), 0);
        chk("bp_d1", qget(load_d, 1), 5);
        chk("bp_d2", qget(load_d, 2), 9);
        chk("bp_d3", qget(load_d, 3), 13);
        chk("bp_ndone", done_cyc.size(), 4);

        // abort on the 4th counting cycle
        clear_logs();
        push_job(0, 15, w);
        push_job(2, 4, w);
        g = 0;
        while (!load && g < 50) begin tick(); g++; end
        chk("abort_load_seen", int'(load), 1);
        tick(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_nodone", done_cyc.size(), 0);
        wait_idle();
        chk("abort_nload", load_d.size(), 2);
        chk("abort_next_d", qget(load_d, 1), 2);
        chk("abort_ndone", done_cyc.size(), 1);

        // reset mid-job with one job queued
        clear_logs();
        push_job(0, 15, w);
        push_job(1, 2, w);
        tick(4);
        rst = 1'b0;
        #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_load", int'(load), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_level", int'(level), 0);
        chk("mrst_d", int'(d), 0);
        tick(2);
        rst = 1'b1;
        clear_logs();
        tick(10);
        chk("mrst_noload", load_cyc.size(), 0);
        push_job(7, 8, w);
        wait_idle();
        chk("mrst_newjob_d", qget(load_d, 0), 7);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s        = $urandom_range(0, MASK);
            t        = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MASK)
                                                   : ((s + $urandom_range(0, 4)) & MASK);
            in_valid = ($urandom_range(0, 1) == 1);
            in_start = W'(s);
            in_term  = W'(t);
            abort    = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
